fl_io_hub: RTL
==============

// Module: fl_io_hub
// PURPOSE
//  Parametrised multi-channel I/O front end for the proc_fl floating-point core.
//  Sits between external integer ports and the proc_fl I/O bus.
//  Inputs: per-channel hold registers with valid/ready, converted by int2float.
//  Outputs: per-channel FIFOs with valid/ready, converted by float2int.
//  Adds handshakes, buffering and error flags; the bare addr_dec wrapper has none.
// PARAMETERS
//  NBMANT  19  mantissa bits of proc_fl float
//  NBEXPO  8   exponent bits; float width FW = NBMANT+NBEXPO+1
//  IWID    19  external input integer width (signed)
//  NUIOIN  4   number of input channels (>=1)
//  NUIOOU  4   number of output channels (>=1)
//  ODEPTH  4   per-output-channel FIFO depth (power of two, >=2)
// PORTS
//  clk        in   1               clock
//  rst        in   1               synchronous reset, active-low
//  in_data    in   NUIOIN*IWID     packed signed samples, channel i at [i*IWID +: IWID]
//  in_valid   in   NUIOIN          sample present on channel i
//  in_ready   out  NUIOIN          hold register i can accept
//  proc_req   in   1               proc_fl input request strobe
//  proc_ain   in   clog2(NUIOIN)   input channel address
//  proc_din   out  FW              float of selected hold register (combinational)
//  proc_oen   in   1               proc_fl output enable strobe
//  proc_aout  in   clog2(NUIOOU)   output channel address
//  proc_dout  in   FW              float result from proc_fl
//  out_data   out  NUIOOU*FW       packed signed integers, channel j at [j*FW +: FW]
//  out_valid  out  NUIOOU          FIFO j non-empty
//  out_ready  in   NUIOOU          consumer takes head of FIFO j
//  err_udr    out  NUIOIN          sticky: channel read while not fresh
//  err_ovf    out  NUIOOU          sticky: write to full FIFO
// BEHAVIOUR
//  Reset (rst=0 at edge): hold regs=0, fresh=0, FIFO pointers=0, err_*=0.
//   Outputs after reset: in_ready=all 1, out_valid=0, out_data=0, proc_din=0.
//  Input accept: in_valid[i]&in_ready[i] latches the sample and sets fresh[i].
//   in_ready[i] = !fresh[i] | consume[i].
//  Consume: proc_req and proc_ain<NUIOIN clear fresh[i] at the edge.
//   proc_din is the float of the held value in the same cycle (0 latency).
//   If fresh=0 at consume: the old value is returned and err_udr[i] is set.
//  Same-cycle accept and consume on one channel: processor gets the old value.
//   The new value is latched and fresh stays 1.
//  Out-of-range address (non-power-of-two counts):
//   proc_req gives proc_din=0 and changes no state.
//   proc_oen is ignored.
//  Output push: proc_oen writes float2int(proc_dout) into FIFO[proc_aout] at the edge.
//   out_valid rises the next cycle (latency 1).
//  Pop: out_valid[j]&out_ready[j] advances head. out_data[j] always shows the head.
//  Full FIFO on push, no pop: word dropped, err_ovf[j] set.
//  Full FIFO on push with pop the same cycle: push accepted, no error.
//  Pointers carry one extra wrap bit; full=(wr^rd)==ODEPTH, empty=(wr==rd).
//  Sticky flags clear only on reset.
// CONFIGURATION
//  FL_IO_ERRCNT_EN defined:
//   Adds output err_cnt [15:0]: saturating count of all udr+ovf events.
//   Simultaneous events add their popcount; holds at 16'hFFFF.
//  Not defined: port absent, sticky flags only.
// STRUCTURE
//  Package fl_io_pkg:
//   FW function, default NBMANT/NBEXPO constants.
//   Packed-channel slice macros/functions.
//  Sub-module fl_io_fifo: one per output channel, generate loop, parameters FW/ODEPTH.
//  Conversion: reuse existing int2float (×1, after the input mux) and float2int (×1, before the FIFOs).
// TESTING
//  1 Reset, then in_valid[2]=1, in_data ch2=5 -> in_ready[2]=0 next cycle.
//    proc_req ain=2 -> proc_din=float(5.0); fresh clears; in_ready[2]=1.
//  2 proc_req ain=1 with no data -> proc_din=0.0, err_udr[1]=1, err_udr stays set.
//  3 Same cycle: ch0 accepts 7 while ch0 holds 3 and proc_req ain=0.
//    -> proc_din=float(3); next proc_req returns 7 with no error.
//  4 Four proc_oen writes aout=3 (1.0..4.0), out_ready=0 -> out_valid[3]=1 at t+1, FIFO full.
//    Fifth write -> dropped, err_ovf[3]=1. Pop order: 1,2,3,4.
//  5 Full FIFO, push 9.0 with out_ready=1 same cycle -> no ovf; 9 emerges last.
//  6 rst=0 mid-transfer with FIFOs half full -> next cycle all out_valid=0, err_*=0, in_ready=1.
//    With FL_IO_ERRCNT_EN: err_cnt=0.

Source files
------------

// File: rtl/fl_io_pkg.sv
// rtl/fl_io_pkg.sv - shared constants and helpers for the proc_fl I/O hub
package fl_io_pkg;

   localparam int NBMANT_DEF = 19;
   localparam int NBEXPO_DEF = 8;

   // proc_fl float layout: {sign, exponent (two's complement), mantissa magnitude}
   function automatic int fl_width(input int nbmant, input int nbexpo);
      return nbmant + nbexpo + 1;
   endfunction

   // channel address width, never zero so single-channel builds still have a port
   function automatic int addr_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// pick channel idx_ out of a packed multi-channel vector
`define FL_IO_SLICE(vec_, idx_, w_) vec_[(idx_)*(w_) +: (w_)]

// File: rtl/fl_io_conv.sv
// rtl/fl_io_conv.sv - int2float and float2int converters for the proc_fl float format
module fl_io_int2float #(
   parameter int IWID   = 19,
   parameter int NBMANT = 19,
   parameter int NBEXPO = 8,
   localparam int FW    = NBMANT + NBEXPO + 1
) (
   input  logic [IWID-1:0] int_i,
   output logic [FW-1:0]   flt_o
);
   localparam int MW = (IWID > NBMANT) ? IWID : NBMANT;

   logic [IWID-1:0]   abs_v;
   logic [MW-1:0]     mag;
   logic [NBMANT-1:0] mant;
   int                lead;
   int                expo;

   // normalise |int_i| so the mantissa MSB is set; zero maps to the all-zero word
   always_comb begin
      abs_v = int_i[IWID-1] ? -int_i : int_i;
      mag   = MW'(abs_v);
      lead  = 0;
      for (int b = 0; b < MW; b++) begin
         if (mag[b]) lead = b;
      end
      expo = lead - (NBMANT - 1);
      if (lead >= NBMANT - 1) begin
         mant = NBMANT'(mag >> (lead - (NBMANT - 1)));
      end else begin
         mant = NBMANT'(mag << ((NBMANT - 1) - lead));
      end
      flt_o = (mag == '0) ? '0 : {int_i[IWID-1], NBEXPO'(expo), mant};
   end
endmodule

module fl_io_float2int #(
   parameter int NBMANT = 19,
   parameter int NBEXPO = 8,
   localparam int FW    = NBMANT + NBEXPO + 1
) (
   input  logic [FW-1:0] flt_i,
   output logic [FW-1:0] int_o
);
   logic [NBMANT-1:0] mant;
   logic [FW-2:0]     mag;
   int                expo;

   // scale the mantissa by 2^expo, truncating fractions and saturating large magnitudes
   always_comb begin
      mant = flt_i[NBMANT-1:0];
      expo = int'($signed(flt_i[FW-2 -: NBEXPO]));
      if (mant == '0) begin
         mag = '0;
      end else if (expo > NBEXPO) begin
         mag = '1;
      end else if (expo >= 0) begin
         mag = (FW-1)'(mant) << expo;
      end else if (-expo >= NBMANT) begin
         mag = '0;
      end else begin
         mag = (FW-1)'(mant >> (-expo));
      end
      int_o = flt_i[FW-1] ? -{1'b0, mag} : {1'b0, mag};
   end
endmodule

// File: rtl/fl_io_fifo.sv
// rtl/fl_io_fifo.sv - per-output-channel FIFO with wrap-bit pointers and overflow drop
module fl_io_fifo #(
   parameter int FW     = 28,
   parameter int ODEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [FW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [FW-1:0] rdata_o,
   output logic          empty_o,
   output logic          drop_o
);
   localparam int PW = $clog2(ODEPTH);

   logic [PW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [FW-1:0] mem_q [ODEPTH];
   logic          full, do_pop, do_push;

   // a pop in the same cycle frees the slot a push into a full FIFO needs
   always_comb begin
      empty_o = (wr_q == rd_q);
      full    = ((wr_q ^ rd_q) == {1'b1, {PW{1'b0}}});
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full | do_pop);
      drop_o  = push_i & full & ~do_pop;
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
      rdata_o = empty_o ? '0 : mem_q[rd_q[PW-1:0]];
   end

   // pointer registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // storage needs no reset: the head is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[PW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/fl_io_hub.sv
// rtl/fl_io_hub.sv - proc_fl I/O front end; FL_IO_ERRCNT_EN adds a saturating err_cnt output
module fl_io_hub
   import fl_io_pkg::*;
#(
   parameter int NBMANT = NBMANT_DEF,
   parameter int NBEXPO = NBEXPO_DEF,
   parameter int IWID   = 19,
   parameter int NUIOIN = 4,
   parameter int NUIOOU = 4,
   parameter int ODEPTH = 4,
   localparam int FW    = fl_width(NBMANT, NBEXPO),
   localparam int AINW  = addr_width(NUIOIN),
   localparam int AOUW  = addr_width(NUIOOU)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUIOIN*IWID-1:0] in_data,
   input  logic [NUIOIN-1:0]      in_valid,
   output logic [NUIOIN-1:0]      in_ready,
   input  logic                   proc_req,
   input  logic [AINW-1:0]        proc_ain,
   output logic [FW-1:0]          proc_din,
   input  logic                   proc_oen,
   input  logic [AOUW-1:0]        proc_aout,
   input  logic [FW-1:0]          proc_dout,
   output logic [NUIOOU*FW-1:0]   out_data,
   output logic [NUIOOU-1:0]      out_valid,
   input  logic [NUIOOU-1:0]      out_ready,
   output logic [NUIOIN-1:0]      err_udr,
   output logic [NUIOOU-1:0]      err_ovf
`ifdef FL_IO_ERRCNT_EN
   ,
   output logic [15:0]            err_cnt
`endif
);
   logic [IWID-1:0]   hold_q [NUIOIN];
   logic [IWID-1:0]   hold_d [NUIOIN];
   logic [NUIOIN-1:0] fresh_q, fresh_d, udr_q, udr_d;
   logic [NUIOIN-1:0] consume, accept, udr_evt;
   logic [NUIOOU-1:0] ovf_q, ovf_d, push, drop, empty;
   logic              ain_ok;
   logic [IWID-1:0]   sel_int;
   logic [FW-1:0]     wr_int;

   // input hold registers: an accept always wins over a consume on the same channel
   always_comb begin
      consume = '0;
      for (int i = 0; i < NUIOIN; i++) begin
         consume[i] = proc_req && (int'(proc_ain) == i);
      end
      in_ready = ~fresh_q | consume;
      accept   = in_valid & in_ready;
      udr_evt  = consume & ~fresh_q;
      udr_d    = udr_q | udr_evt;
      fresh_d  = (fresh_q & ~consume) | accept;
      hold_d   = hold_q;
      for (int i = 0; i < NUIOIN; i++) begin
         if (accept[i]) hold_d[i] = `FL_IO_SLICE(in_data, i, IWID);
      end
   end

   // one converter after the read mux; unmapped addresses read as zero
   always_comb begin
      ain_ok  = int'(proc_ain) < NUIOIN;
      sel_int = ain_ok ? hold_q[proc_ain] : '0;
   end

   fl_io_int2float #(.IWID(IWID), .NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_i2f (
      .int_i (sel_int),
      .flt_o (proc_din)
   );

   // output write decode; unmapped addresses match no channel and are ignored
   always_comb begin
      push = '0;
      for (int j = 0; j < NUIOOU; j++) begin
         push[j] = proc_oen && (int'(proc_aout) == j);
      end
      ovf_d = ovf_q | drop;
   end

   fl_io_float2int #(.NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_f2i (
      .flt_i (proc_dout),
      .int_o (wr_int)
   );

   for (genvar j = 0; j < NUIOOU; j++) begin : g_out
      fl_io_fifo #(.FW(FW), .ODEPTH(ODEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[j]),
         .wdata_i (wr_int),
         .pop_i   (out_ready[j]),
         .rdata_o (`FL_IO_SLICE(out_data, j, FW)),
         .empty_o (empty[j]),
         .drop_o  (drop[j])
      );
   end

   assign out_valid = ~empty;
   assign err_udr   = udr_q;
   assign err_ovf   = ovf_q;

   // hold, freshness and sticky error state
   always_ff @(posedge clk) begin
      if (!rst) begin
         fresh_q <= '0;
         udr_q   <= '0;
         ovf_q   <= '0;
         for (int i = 0; i < NUIOIN; i++) hold_q[i] <= '0;
      end else begin
         fresh_q <= fresh_d;
         udr_q   <= udr_d;
         ovf_q   <= ovf_d;
         hold_q  <= hold_d;
      end
   end

`ifdef FL_IO_ERRCNT_EN
   logic [15:0] cnt_q, cnt_d;
   logic [16:0] cnt_sum;

   // simultaneous events add together; the count sticks at all-ones
   always_comb begin
      cnt_sum = 17'(cnt_q) + 17'($countones(udr_evt)) + 17'($countones(drop));
      cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   // error event counter
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign err_cnt = cnt_q;
`endif
endmodule
